// File: rtl/smadd_pkg.sv
// ---------------------------------------------------------------------------
// smadd_pkg
//   Shared definitions for the sign-magnitude adder sequencer.
//   - state_t     : FSM state encoding (ST_IDLE, ST_CMP, ST_EXEC, ST_DONE)
//   - SMADD_W     : default magnitude width
//   - SIGN_BYTE_W : width of the packed sign byte presented to the bus path
// ---------------------------------------------------------------------------
package smadd_pkg;

    localparam int SMADD_W     = 8;
    localparam int SIGN_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : smadd_pkg

// File: rtl/sign_mag_adder_ctrl_sign_byte_pack.sv
// ---------------------------------------------------------------------------
// sign_byte_pack
//   Combinational packer: widens a 1-bit sign into the byte format used by
//   the display/bus path, {7'b0, sign}.
//   Ports:
//     sign       in   1             sign bit (1 = negative)
//     sign_byte  out  SIGN_BYTE_W   {zeros, sign}
// ---------------------------------------------------------------------------
module sign_byte_pack
    import smadd_pkg::*;
(
    input  logic                   sign,
    output logic [SIGN_BYTE_W-1:0] sign_byte
);

    assign sign_byte = {{(SIGN_BYTE_W-1){1'b0}}, sign};

endmodule : sign_byte_pack

// File: rtl/sign_mag_adder_ctrl.sv
// ---------------------------------------------------------------------------
// sign_mag_adder_ctrl
//   Multi-cycle sequencer for a sign-magnitude adder. Operands are latched
//   on start, magnitudes are ordered, add or subtract is chosen from the
//   effective signs, and the result is registered and held until the next
//   completion.
//
//   Handshake (start/busy/done):
//     start is sampled only while idle (busy=0); the operands present at
//     that edge are latched and later input changes have no effect. busy is
//     high from the accepting edge until the sequencer is idle again. done
//     is a registered one-cycle pulse; res_mag/res_sign_byte/ovf are valid
//     from that cycle and held until the next done or reset. start while
//     busy is dropped, nothing is queued. Accept-to-accept spacing is 4
//     cycles minimum, so start held high yields one operation every 4.
//
//   Ports:
//     clk            in   1   rising-edge clock
//     rst            in   1   asynchronous active-high reset
//     start          in   1   operation request
//     op_sub         in   1   0 = A+B, 1 = A-B
//     a_sign, a_mag  in   1,W operand A (sign-magnitude)
//     b_sign, b_mag  in   1,W operand B (sign-magnitude)
//     busy           out  1   operation in flight (state != IDLE)
//     done           out  1   one-cycle completion pulse
//     res_mag        out  W   result magnitude (held)
//     res_sign_byte  out  8   {7'b0, result sign} (held)
//     ovf            out  1   magnitude overflow on add (held)
//
//   Build option: SMADD_SATURATE_EN -- when defined, an overflowing add
//   clamps res_mag to all ones instead of wrapping. ovf is unaffected.
// ---------------------------------------------------------------------------
module sign_mag_adder_ctrl
    import smadd_pkg::*;
#(
    parameter int W = SMADD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic                   a_sign,
    input  logic [W-1:0]           a_mag,
    input  logic                   b_sign,
    input  logic [W-1:0]           b_mag,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           res_mag,
    output logic [SIGN_BYTE_W-1:0] res_sign_byte,
    output logic                   ovf
);

    state_t state;
    state_t state_nxt;

    logic         accept;
    logic         a_sign_q;
    logic [W-1:0] a_mag_q;
    logic         eb_q;
    logic [W-1:0] b_mag_q;
    logic         same_q;
    logic         swap_q;

    logic         res_sign_q;

    logic [W:0]   exec_sum;
    logic [W-1:0] exec_mag;
    logic         exec_sign;
    logic         exec_ovf;

    assign accept = (state == ST_IDLE) && start;
    assign busy   = (state != ST_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CMP;
            ST_CMP:  state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- operand capture ----------------
    // op_sub is folded into B's sign here so later stages only ever add
    // signed quantities.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sign_q <= 1'b0;
            a_mag_q  <= '0;
            eb_q     <= 1'b0;
            b_mag_q  <= '0;
        end else if (accept) begin
            a_sign_q <= a_sign;
            a_mag_q  <= a_mag;
            eb_q     <= b_sign ^ op_sub;
            b_mag_q  <= b_mag;
        end
    end

    // ---------------- compare stage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            same_q <= 1'b0;
            swap_q <= 1'b0;
        end else if (state == ST_CMP) begin
            same_q <= (a_sign_q == eb_q);
            swap_q <= (b_mag_q > a_mag_q);
        end
    end

    // ---------------- execute datapath ----------------
    always_comb begin
        exec_sum  = {1'b0, a_mag_q} + {1'b0, b_mag_q};
        exec_mag  = '0;
        exec_sign = 1'b0;
        exec_ovf  = 1'b0;
        if (same_q) begin
            exec_ovf  = exec_sum[W];
            exec_sign = a_sign_q;
`ifdef SMADD_SATURATE_EN
            exec_mag  = exec_sum[W] ? {W{1'b1}} : exec_sum[W-1:0];
`else
            exec_mag  = exec_sum[W-1:0];
`endif
        end else if (swap_q) begin
            exec_mag  = b_mag_q - a_mag_q;
            exec_sign = eb_q;
        end else begin
            // A is larger or equal; a tie yields zero and is cleared below.
            exec_mag  = a_mag_q - b_mag_q;
            exec_sign = a_sign_q;
        end
        // Zero is always reported positive, which also absorbs -0 inputs.
        if (exec_mag == '0) begin
            exec_sign = 1'b0;
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_mag    <= '0;
            res_sign_q <= 1'b0;
            ovf        <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == ST_EXEC);
            if (state == ST_EXEC) begin
                res_mag    <= exec_mag;
                res_sign_q <= exec_sign;
                ovf        <= exec_ovf;
            end
        end
    end

    sign_byte_pack u_sign_byte_pack (
        .sign      (res_sign_q),
        .sign_byte (res_sign_byte)
    );

endmodule : sign_mag_adder_ctrl
